// File: rtl/id_ex_stage_pkg.sv
// ----------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the ID/EX pipeline stage:
//   - default datapath / register-address widths
//   - ALU operation encodings (ALU_ADD, ALU_SUB, ALU_OR)
//   - the control-field bundle carried by the stage register and the
//     bubble value loaded on flush, load-use stall or reset
// ----------------------------------------------------------------------------
package cpu_pkg;

  localparam int XLEN_DEFAULT = 32;
  localparam int RW_DEFAULT   = 5;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_OR  = 3'b010
  } alu_op_e;

  // Control half of the stage register. Everything in here must be forced
  // to a harmless value when a bubble is inserted; data fields are not.
  typedef struct packed {
    logic       valid;
    logic [2:0] alu_op;
    logic       alu_src;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
  } ex_ctrl_t;

  localparam ex_ctrl_t BUBBLE_CTRL = '{
    valid:     1'b0,
    alu_op:    ALU_ADD,
    alu_src:   1'b0,
    reg_write: 1'b0,
    mem_read:  1'b0,
    mem_write: 1'b0
  };

endpackage

// File: rtl/id_ex_stage_fwd_mux.sv
// ----------------------------------------------------------------------------
// fwd_mux
// Operand forwarding selector for one EX source operand. Picks the newest
// value of the operand's source register from the MEM stage, then the WB
// stage, otherwise passes the latched operand through.
//
// Ports:
//   operand        in  XLEN  value latched in the ID/EX register
//   src_addr       in  RW    register the operand was read from
//   mem_reg_write  in  1     MEM stage will write its rd
//   mem_rd_addr    in  RW    MEM stage destination
//   mem_result     in  XLEN  MEM stage result
//   wb_reg_write   in  1     WB stage will write its rd
//   wb_rd_addr     in  RW    WB stage destination
//   wb_result      in  XLEN  WB stage result
//   value          out XLEN  forwarded operand
//
// Configuration: only built when FORWARD_EN is defined; the non-forwarding
// build has no use for it.
// ----------------------------------------------------------------------------
`ifdef FORWARD_EN
module fwd_mux #(
  parameter int XLEN = 32,
  parameter int RW   = 5
) (
  input  logic [XLEN-1:0] operand,
  input  logic [RW-1:0]   src_addr,
  input  logic            mem_reg_write,
  input  logic [RW-1:0]   mem_rd_addr,
  input  logic [XLEN-1:0] mem_result,
  input  logic            wb_reg_write,
  input  logic [RW-1:0]   wb_rd_addr,
  input  logic [XLEN-1:0] wb_result,
  output logic [XLEN-1:0] value
);

  logic mem_hit;
  logic wb_hit;

  // r0 is hardwired to zero, so a write to it must never be forwarded.
  assign mem_hit = mem_reg_write && (mem_rd_addr != '0) && (mem_rd_addr == src_addr);
  assign wb_hit  = wb_reg_write  && (wb_rd_addr  != '0) && (wb_rd_addr  == src_addr);

  // MEM holds the younger result, so it wins over WB.
  always_comb begin
    value = operand;
    if (mem_hit) begin
      value = mem_result;
    end else if (wb_hit) begin
      value = wb_result;
    end
  end

endmodule
`endif

// File: rtl/id_ex_stage.sv
// ----------------------------------------------------------------------------
// id_ex_stage
// ID/EX pipeline register. Latches a decoded instruction and presents the
// EX-stage ALU operands. Detects load-use hazards (freezing PC/IF-ID and
// inserting a bubble), honours branch flush and back-end hold, and forwards
// MEM/WB results into the latched operands.
//
// Ports:
//   clk, reset                      clock, synchronous active-low reset
//   id_valid, id_pc, id_rs_data, id_rt_data, id_imm
//   id_rs_addr, id_rt_addr, id_rd_addr
//   id_alu_op, id_alu_src, id_reg_write, id_mem_read, id_mem_write
//                                   decoded instruction from ID
//   flush                           kill the instruction being captured
//   ex_hold                         back end frozen, keep contents
//   mem_reg_write/mem_rd_addr/mem_result, wb_reg_write/wb_rd_addr/wb_result
//                                   forwarding and write-through sources
//   hazard_stall                    freeze PC and IF/ID (combinational)
//   ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_pc, ex_rd_addr
//   alu_a, alu_b, alu_op, ex_store_data
//                                   EX-stage outputs
//
// Configuration macro: FORWARD_EN
//   defined   -> MEM/WB forwarding muxes on the operands, stall only on
//                load-use.
//   undefined -> operands straight from the register, stall on any RAW
//                dependence on EX or MEM. WB write-through is in both.
// ----------------------------------------------------------------------------
module id_ex_stage
  import cpu_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT,
  parameter int RW   = RW_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            id_valid,
  input  logic [XLEN-1:0] id_pc,
  input  logic [XLEN-1:0] id_rs_data,
  input  logic [XLEN-1:0] id_rt_data,
  input  logic [XLEN-1:0] id_imm,
  input  logic [RW-1:0]   id_rs_addr,
  input  logic [RW-1:0]   id_rt_addr,
  input  logic [RW-1:0]   id_rd_addr,
  input  logic [2:0]      id_alu_op,
  input  logic            id_alu_src,
  input  logic            id_reg_write,
  input  logic            id_mem_read,
  input  logic            id_mem_write,
  input  logic            flush,
  input  logic            ex_hold,
  input  logic            mem_reg_write,
  input  logic [RW-1:0]   mem_rd_addr,
  input  logic [XLEN-1:0] mem_result,
  input  logic            wb_reg_write,
  input  logic [RW-1:0]   wb_rd_addr,
  input  logic [XLEN-1:0] wb_result,
  output logic            hazard_stall,
  output logic            ex_valid,
  output logic            ex_reg_write,
  output logic            ex_mem_read,
  output logic            ex_mem_write,
  output logic [XLEN-1:0] ex_pc,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [XLEN-1:0] ex_store_data,
  output logic [2:0]      alu_op,
  output logic [RW-1:0]   ex_rd_addr
);

  ex_ctrl_t        ctrl_q;
  ex_ctrl_t        id_ctrl;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] rs_data_q;
  logic [XLEN-1:0] rt_data_q;
  logic [XLEN-1:0] imm_q;
  logic [RW-1:0]   rs_addr_q;
  logic [RW-1:0]   rt_addr_q;
  logic [RW-1:0]   rd_q;

  logic [XLEN-1:0] rs_capture;
  logic [XLEN-1:0] rt_capture;
  logic [XLEN-1:0] rs_fwd;
  logic [XLEN-1:0] rt_fwd;

  // True when register 'src' is a nonzero register equal to 'dest'.
  function automatic logic same_reg(logic [RW-1:0] src, logic [RW-1:0] dest);
    return (src != '0) && (src == dest);
  endfunction

  assign id_ctrl = '{
    valid:     id_valid,
    alu_op:    id_alu_op,
    alu_src:   id_alu_src,
    reg_write: id_reg_write,
    mem_read:  id_mem_read,
    mem_write: id_mem_write
  };

  // The register file is read in ID while WB writes in the same cycle, so the
  // RF output may still be stale; substitute the WB result on a match.
  always_comb begin
    rs_capture = id_rs_data;
    rt_capture = id_rt_data;
    if (wb_reg_write && same_reg(id_rs_addr, wb_rd_addr)) begin
      rs_capture = wb_result;
    end
    if (wb_reg_write && same_reg(id_rt_addr, wb_rd_addr)) begin
      rt_capture = wb_result;
    end
  end

  // Hazard detection. Flush always suppresses the stall because the
  // instruction in ID is being discarded anyway.
  always_comb begin
    hazard_stall = 1'b0;
`ifdef FORWARD_EN
    // Only a load in EX cannot be covered by forwarding: its data exists
    // one cycle later in MEM.
    if (id_valid && !flush && ctrl_q.valid && ctrl_q.mem_read && (rd_q != '0) &&
        ((rd_q == id_rs_addr) || (rd_q == id_rt_addr))) begin
      hazard_stall = 1'b1;
    end
`else
    // Without forwarding, anything not yet written back is a hazard.
    if (id_valid && !flush) begin
      if (ctrl_q.reg_write &&
          (same_reg(id_rs_addr, rd_q) || same_reg(id_rt_addr, rd_q))) begin
        hazard_stall = 1'b1;
      end
      if (mem_reg_write &&
          (same_reg(id_rs_addr, mem_rd_addr) || same_reg(id_rt_addr, mem_rd_addr))) begin
        hazard_stall = 1'b1;
      end
    end
`endif
  end

  // Stage register. Priority: reset, flush, hold, stall, capture. Bubbles
  // only touch the control half and rd; stale data is harmless once
  // valid and all write enables are low.
  always_ff @(posedge clk) begin
    if (!reset) begin
      ctrl_q    <= BUBBLE_CTRL;
      pc_q      <= '0;
      rs_data_q <= '0;
      rt_data_q <= '0;
      imm_q     <= '0;
      rs_addr_q <= '0;
      rt_addr_q <= '0;
      rd_q      <= '0;
    end else if (flush) begin
      ctrl_q <= BUBBLE_CTRL;
      rd_q   <= '0;
    end else if (!ex_hold) begin
      if (hazard_stall) begin
        ctrl_q <= BUBBLE_CTRL;
        rd_q   <= '0;
      end else begin
        ctrl_q    <= id_ctrl;
        pc_q      <= id_pc;
        rs_data_q <= rs_capture;
        rt_data_q <= rt_capture;
        imm_q     <= id_imm;
        rs_addr_q <= id_rs_addr;
        rt_addr_q <= id_rt_addr;
        rd_q      <= id_rd_addr;
      end
    end
  end

  // Operand forwarding from MEM/WB onto the latched source values.
`ifdef FORWARD_EN
  fwd_mux #(.XLEN(XLEN), .RW(RW)) u_fwd_rs (
    .operand       (rs_data_q),
    .src_addr      (rs_addr_q),
    .mem_reg_write (mem_reg_write),
    .mem_rd_addr   (mem_rd_addr),
    .mem_result    (mem_result),
    .wb_reg_write  (wb_reg_write),
    .wb_rd_addr    (wb_rd_addr),
    .wb_result     (wb_result),
    .value         (rs_fwd)
  );

  fwd_mux #(.XLEN(XLEN), .RW(RW)) u_fwd_rt (
    .operand       (rt_data_q),
    .src_addr      (rt_addr_q),
    .mem_reg_write (mem_reg_write),
    .mem_rd_addr   (mem_rd_addr),
    .mem_result    (mem_result),
    .wb_reg_write  (wb_reg_write),
    .wb_rd_addr    (wb_rd_addr),
    .wb_result     (wb_result),
    .value         (rt_fwd)
  );
`else
  // The latched source addresses and the MEM result only feed forwarding.
  logic unused_fwd;
  assign unused_fwd = ^{mem_result, rs_addr_q, rt_addr_q};

  assign rs_fwd = rs_data_q;
  assign rt_fwd = rt_data_q;
`endif

  assign alu_a         = rs_fwd;
  assign ex_store_data = rt_fwd;
  assign alu_b         = ctrl_q.alu_src ? imm_q : rt_fwd;
  assign alu_op        = ctrl_q.alu_op;

  assign ex_valid      = ctrl_q.valid;
  assign ex_reg_write  = ctrl_q.reg_write;
  assign ex_mem_read   = ctrl_q.mem_read;
  assign ex_mem_write  = ctrl_q.mem_write;
  assign ex_pc         = pc_q;
  assign ex_rd_addr    = rd_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// ----------------------------------------------------------------------------
// tb_id_ex_stage
// Self-checking bench for id_ex_stage. A directed table walks through reset,
// operand select, MEM/WB forwarding, load-use stall, WB write-through, flush,
// hold and r0 handling; a randomized phase is then compared against an
// instruction-level reference model. Expectations follow FORWARD_EN.
// ----------------------------------------------------------------------------
module tb_id_ex_stage;

`ifdef FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        id_valid;
  logic [31:0] id_pc, id_rs_data, id_rt_data, id_imm;
  logic [4:0]  id_rs_addr, id_rt_addr, id_rd_addr;
  logic [2:0]  id_alu_op;
  logic        id_alu_src, id_reg_write, id_mem_read, id_mem_write;
  logic        flush, ex_hold;
  logic        mem_reg_write, wb_reg_write;
  logic [4:0]  mem_rd_addr, wb_rd_addr;
  logic [31:0] mem_result, wb_result;
  logic        hazard_stall, ex_valid, ex_reg_write, ex_mem_read, ex_mem_write;
  logic [31:0] ex_pc, alu_a, alu_b, ex_store_data;
  logic [2:0]  alu_op;
  logic [4:0]  ex_rd_addr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_pc(id_pc),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr), .id_rd_addr(id_rd_addr),
    .id_alu_op(id_alu_op), .id_alu_src(id_alu_src), .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read), .id_mem_write(id_mem_write), .flush(flush),
    .ex_hold(ex_hold), .mem_reg_write(mem_reg_write), .mem_rd_addr(mem_rd_addr),
    .mem_result(mem_result), .wb_reg_write(wb_reg_write), .wb_rd_addr(wb_rd_addr),
    .wb_result(wb_result), .hazard_stall(hazard_stall), .ex_valid(ex_valid),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_pc(ex_pc), .alu_a(alu_a), .alu_b(alu_b),
    .ex_store_data(ex_store_data), .alu_op(alu_op), .ex_rd_addr(ex_rd_addr)
  );

  typedef struct {
    logic        rst_n, id_valid;
    logic [31:0] pc, rs_data, rt_data, imm;
    logic [4:0]  rs, rt, rd;
    logic [2:0]  op;
    logic        src, rw, mr, mw, flush, hold;
    logic        mem_rw;
    logic [4:0]  mem_rd;
    logic [31:0] mem_res;
    logic        wb_rw;
    logic [4:0]  wb_rd;
    logic [31:0] wb_res;
  } stim_t;

  // chk: 0 = nothing, 1 = control + stall, 2 = also pc and operands
  typedef struct {
    string       name;
    stim_t       s;
    int          chk;
    logic        v, rw, mr, hz;
    logic [4:0]  rd;
    logic [2:0]  op;
    logic [31:0] pc, a, b, st;
  } vec_t;

  // Reference model: the instruction currently sitting in EX.
  typedef struct {
    logic        valid, use_imm, writes, loads, stores, data_known;
    logic [31:0] pc, a_data, b_data, imm;
    logic [4:0]  src1, src2, dest;
    logic [2:0]  op;
  } instr_t;

  instr_t ex_m;
  vec_t   vecs[$];

  function automatic stim_t idle();
    stim_t s;
    s = '{rst_n: 1'b1, default: '0};
    return s;
  endfunction

  function automatic stim_t instr(logic [31:0] pc, logic [4:0] rs, logic [31:0] rsd,
                                  logic [4:0] rt, logic [31:0] rtd, logic [31:0] imm,
                                  logic [4:0] rd, logic [2:0] op, logic src,
                                  logic rw, logic mr);
    stim_t s;
    s = idle();
    s.id_valid = 1'b1; s.pc = pc; s.rs = rs; s.rs_data = rsd; s.rt = rt;
    s.rt_data = rtd; s.imm = imm; s.rd = rd; s.op = op; s.src = src;
    s.rw = rw; s.mr = mr;
    return s;
  endfunction

  function automatic vec_t mkv(string name, stim_t s, int chk, logic v, logic rw,
                               logic mr, logic [4:0] rd, logic [2:0] op, logic hz,
                               logic [31:0] pc, logic [31:0] a, logic [31:0] b,
                               logic [31:0] st);
    vec_t t;
    t.name = name; t.s = s; t.chk = chk; t.v = v; t.rw = rw; t.mr = mr;
    t.rd = rd; t.op = op; t.hz = hz; t.pc = pc; t.a = a; t.b = b; t.st = st;
    return t;
  endfunction

  function automatic vec_t zeros(string name, stim_t s, logic hz);
    return mkv(name, s, 2, 0, 0, 0, 0, 0, hz, 0, 0, 0, 0);
  endfunction

  function automatic vec_t bubble(string name, stim_t s, logic hz);
    return mkv(name, s, 1, 0, 0, 0, 0, 0, hz, 0, 0, 0, 0);
  endfunction

  // ---- reference model --------------------------------------------------
  function automatic logic reads_reg(logic [4:0] r, stim_t s);
    return s.id_valid && (r != 0) && ((r == s.rs) || (r == s.rt));
  endfunction

  function automatic logic model_hazard(stim_t s);
    if (!s.id_valid || s.flush) return 1'b0;
    if (FWD) return ex_m.valid && ex_m.loads && reads_reg(ex_m.dest, s);
    return (ex_m.writes && reads_reg(ex_m.dest, s)) ||
           (s.mem_rw && reads_reg(s.mem_rd, s));
  endfunction

  function automatic logic [31:0] model_operand(logic [31:0] latched, logic [4:0] r, stim_t s);
    if (FWD && r != 0 && s.mem_rw && s.mem_rd == r) return s.mem_res;
    if (FWD && r != 0 && s.wb_rw && s.wb_rd == r) return s.wb_res;
    return latched;
  endfunction

  function automatic logic [31:0] write_through(logic [31:0] d, logic [4:0] r, stim_t s);
    return (s.wb_rw && r != 0 && s.wb_rd == r) ? s.wb_res : d;
  endfunction

  task automatic model_update(stim_t s, logic hz);
    if (!s.rst_n) begin
      ex_m = '{default: '0};
      ex_m.data_known = 1'b1;
    end else if (s.flush || (!s.hold && hz)) begin
      ex_m.valid = 0; ex_m.writes = 0; ex_m.loads = 0; ex_m.stores = 0;
      ex_m.use_imm = 0; ex_m.dest = 0; ex_m.op = 3'b000; ex_m.data_known = 0;
    end else if (!s.hold) begin
      ex_m.valid = s.id_valid; ex_m.pc = s.pc; ex_m.imm = s.imm;
      ex_m.a_data = write_through(s.rs_data, s.rs, s);
      ex_m.b_data = write_through(s.rt_data, s.rt, s);
      ex_m.src1 = s.rs; ex_m.src2 = s.rt; ex_m.dest = s.rd; ex_m.op = s.op;
      ex_m.use_imm = s.src; ex_m.writes = s.rw; ex_m.loads = s.mr;
      ex_m.stores = s.mw; ex_m.data_known = 1'b1;
    end
  endtask

  // ---- drive / compare ----------------------------------------------------
  task automatic applyStimulus(stim_t s);
    reset = s.rst_n; id_valid = s.id_valid; id_pc = s.pc;
    id_rs_data = s.rs_data; id_rt_data = s.rt_data; id_imm = s.imm;
    id_rs_addr = s.rs; id_rt_addr = s.rt; id_rd_addr = s.rd; id_alu_op = s.op;
    id_alu_src = s.src; id_reg_write = s.rw; id_mem_read = s.mr;
    id_mem_write = s.mw; flush = s.flush; ex_hold = s.hold;
    mem_reg_write = s.mem_rw; mem_rd_addr = s.mem_rd; mem_result = s.mem_res;
    wb_reg_write = s.wb_rw; wb_rd_addr = s.wb_rd; wb_result = s.wb_res;
  endtask

  task automatic checkOutput(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    stim_t s;
    logic  hz;
    ex_m = '{default: '0};
    applyStimulus(idle());

    // ---- directed table ----
    s = instr(32'h100, 1, 5, 2, 9, 7, 10, 3'b000, 1, 1, 0); s.rst_n = 0;
    vecs.push_back(mkv("rst_first", s, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(zeros("rst_held", s, 0));
    s.rst_n = 1;
    vecs.push_back(zeros("rst_done", s, 0));
    vecs.push_back(mkv("imm_sel", idle(), 2, 1, 1, 0, 10, 3'b000, 0, 32'h100, 5, 7, 9));
    s = instr(32'h104, 3, 0, 0, 0, 0, 11, 3'b000, 0, 1, 0);
    vecs.push_back(zeros("fwd_setup", s, 0));
    s = idle(); s.hold = 1; s.mem_rw = 1; s.mem_rd = 3; s.mem_res = 32'h10;
    vecs.push_back(mkv("fwd_mem", s, 2, 1, 1, 0, 11, 3'b000, 0, 32'h104, FWD ? 32'h10 : 0, 0, 0));
    s.wb_rw = 1; s.wb_rd = 3; s.wb_res = 32'h20;
    vecs.push_back(mkv("fwd_mem_over_wb", s, 2, 1, 1, 0, 11, 3'b000, 0, 32'h104, FWD ? 32'h10 : 0, 0, 0));
    s.mem_rw = 0;
    vecs.push_back(mkv("fwd_wb", s, 2, 1, 1, 0, 11, 3'b000, 0, 32'h104, FWD ? 32'h20 : 0, 0, 0));
    s = instr(32'h108, 1, 32'h40, 0, 0, 4, 4, 3'b000, 1, 1, 1);
    vecs.push_back(mkv("lw_enter", s, 2, 1, 1, 0, 11, 3'b000, 0, 32'h104, 0, 0, 0));
    s = instr(32'h10C, 4, 0, 5, 32'h55, 0, 12, 3'b001, 0, 1, 0);
    vecs.push_back(mkv("load_use", s, 2, 1, 1, 1, 4, 3'b000, 1, 32'h108, 32'h40, 4, 0));
    s.mem_rw = 1; s.mem_rd = 4; s.mem_res = 32'h99;
    vecs.push_back(bubble("lu_bubble", s, FWD ? 0 : 1));
    s = idle(); s.mem_rw = 1; s.mem_rd = 4; s.mem_res = 32'h99;
    if (FWD) vecs.push_back(mkv("lu_fwd", s, 2, 1, 1, 0, 12, 3'b001, 0, 32'h10C, 32'h99, 32'h55, 32'h55));
    else     vecs.push_back(bubble("lu_bubble2", s, 0));
    s = instr(32'h110, 6, 0, 0, 0, 0, 13, 3'b000, 0, 1, 0);
    s.wb_rw = 1; s.wb_rd = 6; s.wb_res = 32'hAB;
    vecs.push_back(zeros("wt_capture", s, 0));
    vecs.push_back(mkv("wt_out", idle(), 2, 1, 1, 0, 13, 3'b000, 0, 32'h110, 32'hAB, 0, 0));
    s = instr(32'h114, 0, 0, 0, 0, 8, 7, 3'b000, 1, 1, 1);
    vecs.push_back(zeros("fl_lw", s, 0));
    s = instr(32'h118, 7, 0, 0, 0, 0, 8, 3'b000, 0, 1, 0); s.flush = 1;
    vecs.push_back(mkv("fl_hazard", s, 2, 1, 1, 1, 7, 3'b000, 0, 32'h114, 0, 8, 0));
    s = instr(32'h11C, 1, 32'h1111, 2, 32'h2222, 32'h33, 9, 3'b010, 0, 1, 0);
    vecs.push_back(bubble("fl_bubble", s, 0));
    s = idle(); s.hold = 1;
    vecs.push_back(mkv("hold0", s, 2, 1, 1, 0, 9, 3'b010, 0, 32'h11C, 32'h1111, 32'h2222, 32'h2222));
    s = instr(32'h200, 3, 32'hDEAD, 0, 0, 0, 14, 3'b000, 0, 1, 0); s.hold = 1;
    vecs.push_back(mkv("hold1", s, 2, 1, 1, 0, 9, 3'b010, 0, 32'h11C, 32'h1111, 32'h2222, 32'h2222));
    vecs.push_back(mkv("hold2", s, 2, 1, 1, 0, 9, 3'b010, 0, 32'h11C, 32'h1111, 32'h2222, 32'h2222));
    vecs.push_back(mkv("hold3", idle(), 2, 1, 1, 0, 9, 3'b010, 0, 32'h11C, 32'h1111, 32'h2222, 32'h2222));
    s = instr(32'h120, 0, 32'h77, 0, 0, 0, 15, 3'b000, 0, 1, 0);
    vecs.push_back(zeros("r0_setup", s, 0));
    s = idle(); s.hold = 1; s.mem_rw = 1; s.mem_rd = 0; s.mem_res = 32'hFFFF_FFFF;
    s.wb_rw = 1; s.wb_rd = 0; s.wb_res = 32'hEEEE;
    vecs.push_back(mkv("r0_nofwd", s, 2, 1, 1, 0, 15, 3'b000, 0, 32'h120, 32'h77, 0, 0));
    s.rst_n = 0;
    vecs.push_back(mkv("rst_in_hold", s, 2, 1, 1, 0, 15, 3'b000, 0, 32'h120, 32'h77, 0, 0));
    vecs.push_back(zeros("rst_cleared", idle(), 0));
    s = instr(32'h124, 0, 0, 0, 0, 0, 4, 3'b000, 0, 1, 1);
    vecs.push_back(zeros("hs_lw", s, 0));
    s = instr(32'h128, 4, 0, 0, 0, 0, 5, 3'b000, 0, 1, 0); s.hold = 1;
    vecs.push_back(mkv("hs_hold0", s, 2, 1, 1, 1, 4, 3'b000, 1, 32'h124, 0, 0, 0));
    vecs.push_back(mkv("hs_hold1", s, 2, 1, 1, 1, 4, 3'b000, 1, 32'h124, 0, 0, 0));
    s.hold = 0;
    vecs.push_back(mkv("hs_release", s, 2, 1, 1, 1, 4, 3'b000, 1, 32'h124, 0, 0, 0));
    vecs.push_back(bubble("hs_bubble", idle(), 0));

    foreach (vecs[i]) begin
      @(negedge clk);
      applyStimulus(vecs[i].s);
      #1;
      if (vecs[i].chk >= 1) begin
        checkOutput({vecs[i].name, ".hazard_stall"}, {31'b0, hazard_stall}, {31'b0, vecs[i].hz});
        checkOutput({vecs[i].name, ".ex_valid"}, {31'b0, ex_valid}, {31'b0, vecs[i].v});
        checkOutput({vecs[i].name, ".ex_reg_write"}, {31'b0, ex_reg_write}, {31'b0, vecs[i].rw});
        checkOutput({vecs[i].name, ".ex_mem_read"}, {31'b0, ex_mem_read}, {31'b0, vecs[i].mr});
        checkOutput({vecs[i].name, ".ex_mem_write"}, {31'b0, ex_mem_write}, 32'h0);
        checkOutput({vecs[i].name, ".ex_rd_addr"}, {27'b0, ex_rd_addr}, {27'b0, vecs[i].rd});
        checkOutput({vecs[i].name, ".alu_op"}, {29'b0, alu_op}, {29'b0, vecs[i].op});
      end
      if (vecs[i].chk >= 2) begin
        checkOutput({vecs[i].name, ".ex_pc"}, ex_pc, vecs[i].pc);
        checkOutput({vecs[i].name, ".alu_a"}, alu_a, vecs[i].a);
        checkOutput({vecs[i].name, ".alu_b"}, alu_b, vecs[i].b);
        checkOutput({vecs[i].name, ".ex_store_data"}, ex_store_data, vecs[i].st);
      end
      hz = model_hazard(vecs[i].s);
      @(posedge clk);
      model_update(vecs[i].s, hz);
    end

    // ---- randomized phase against the reference model ----
    s = idle(); s.rst_n = 0;
    @(negedge clk); applyStimulus(s); @(posedge clk); model_update(s, 1'b0);
    for (int n = 0; n < 600; n++) begin
      s.rst_n    = ($urandom_range(0, 49) != 0);
      s.id_valid = ($urandom_range(0, 3) != 0);
      s.pc       = $urandom; s.rs_data = $urandom; s.rt_data = $urandom; s.imm = $urandom;
      s.rs       = 5'($urandom_range(0, 3)); s.rt = 5'($urandom_range(0, 3));
      s.rd       = 5'($urandom_range(0, 3)); s.op = 3'($urandom_range(0, 2));
      s.src      = 1'($urandom); s.rw = 1'($urandom); s.mr = 1'($urandom); s.mw = 1'($urandom);
      s.flush    = ($urandom_range(0, 9) == 0);
      s.hold     = ($urandom_range(0, 5) == 0);
      s.mem_rw   = 1'($urandom); s.mem_rd = 5'($urandom_range(0, 3)); s.mem_res = $urandom;
      s.wb_rw    = 1'($urandom); s.wb_rd = 5'($urandom_range(0, 3)); s.wb_res = $urandom;
      @(negedge clk);
      applyStimulus(s);
      #1;
      hz = model_hazard(s);
      checkOutput("rnd.hazard_stall", {31'b0, hazard_stall}, {31'b0, hz});
      checkOutput("rnd.ex_valid", {31'b0, ex_valid}, {31'b0, ex_m.valid});
      checkOutput("rnd.ex_reg_write", {31'b0, ex_reg_write}, {31'b0, ex_m.writes});
      checkOutput("rnd.ex_mem_read", {31'b0, ex_mem_read}, {31'b0, ex_m.loads});
      checkOutput("rnd.ex_mem_write", {31'b0, ex_mem_write}, {31'b0, ex_m.stores});
      checkOutput("rnd.ex_rd_addr", {27'b0, ex_rd_addr}, {27'b0, ex_m.dest});
      checkOutput("rnd.alu_op", {29'b0, alu_op}, {29'b0, ex_m.op});
      if (ex_m.data_known) begin
        checkOutput("rnd.ex_pc", ex_pc, ex_m.pc);
        checkOutput("rnd.alu_a", alu_a, model_operand(ex_m.a_data, ex_m.src1, s));
        checkOutput("rnd.alu_b", alu_b,
                    ex_m.use_imm ? ex_m.imm : model_operand(ex_m.b_data, ex_m.src2, s));
        checkOutput("rnd.ex_store_data", ex_store_data, model_operand(ex_m.b_data, ex_m.src2, s));
      end
      @(posedge clk);
      model_update(s, hz);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
